instr_mem_arbiter: RTL

//  Shares the byte-organised, big-endian instruction memory between the fetch stage (read-only) and a

---
 rtl/instr_mem_arbiter.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/instr_mem_arbiter.sv
// Arbitrates the instruction memory between fetch (reads) and the program loader (word writes).
// Loader has priority up to MAX_LD_BURST consecutive grants; all memory controls are registered.
module instr_mem_arbiter #(
  parameter int          ADDR_W       = 32,
  parameter int          MEM_BYTES    = 1024,
  parameter int          MAX_LD_BURST = 4,
  parameter logic [31:0] NOP_WORD     = 32'hE000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [31:0]       if_rdata,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_wdata,
  output logic              ld_gnt,
  output logic              ld_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [31:0]       mem_rdata,
  output logic              freeze
);

  localparam int                CNT_W      = $clog2(MAX_LD_BURST + 1);
  localparam logic [CNT_W-1:0]  BURST_MAX  = CNT_W'(MAX_LD_BURST);
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(MEM_BYTES);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_LOAD} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              ld_err_q, ld_err_d;
  logic              fetch_pend_q, fetch_pend_d;
  logic              fetch_oor_q, fetch_oor_d;
  logic              if_valid_q, if_valid_d;
  logic [31:0]       if_rdata_q, if_rdata_d;

  logic burst_full;
  logic ld_gnt_c;
  logic if_gnt_c;
  logic ld_ok;
  logic if_in_range;

  // Grants are combinational so a requester sees acceptance in the same cycle.
  always_comb begin
    burst_full  = (burst_cnt_q == BURST_MAX);
    ld_gnt_c    = rst && ld_req && !(if_req && burst_full);
    if_gnt_c    = rst && if_req && !ld_gnt_c;
    ld_ok       = (ld_addr[1:0] == 2'b00) && (ld_addr < ADDR_LIMIT);
    if_in_range = (if_addr < ADDR_LIMIT);
  end

  always_comb begin
    state_d      = S_IDLE;
    burst_cnt_d  = burst_cnt_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    ld_err_d     = 1'b0;
    fetch_pend_d = 1'b0;
    fetch_oor_d  = 1'b0;
    if_valid_d   = fetch_pend_q;
    if_rdata_d   = if_rdata_q;

    if (ld_gnt_c) begin
      burst_cnt_d = burst_full ? burst_cnt_q : burst_cnt_q + 1'b1;
    end else if (if_gnt_c || !ld_req) begin
      burst_cnt_d = '0;
    end

    if (ld_gnt_c) begin
      state_d     = S_LOAD;
      mem_addr_d  = {ld_addr[ADDR_W-1:2], 2'b00};
      mem_wdata_d = ld_wdata;
      mem_write_d = ld_ok;
      ld_err_d    = !ld_ok;
    end else if (if_gnt_c) begin
      state_d      = S_FETCH;
      mem_addr_d   = {if_addr[ADDR_W-1:2], 2'b00};
      mem_read_d   = if_in_range;
      fetch_pend_d = 1'b1;
      fetch_oor_d  = !if_in_range;
    end

    // Read data is only meaningful in the cycle mem_read is high, so capture it then.
    if (fetch_pend_q) begin
      if_rdata_d = fetch_oor_q ? NOP_WORD : mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      burst_cnt_q  <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      ld_err_q     <= 1'b0;
      fetch_pend_q <= 1'b0;
      fetch_oor_q  <= 1'b0;
      if_valid_q   <= 1'b0;
      if_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      burst_cnt_q  <= burst_cnt_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      ld_err_q     <= ld_err_d;
      fetch_pend_q <= fetch_pend_d;
      fetch_oor_q  <= fetch_oor_d;
      if_valid_q   <= if_valid_d;
      if_rdata_q   <= if_rdata_d;
    end
  end

  assign if_gnt    = if_gnt_c;
  assign ld_gnt    = ld_gnt_c;
  assign if_valid  = if_valid_q;
  assign if_rdata  = if_rdata_q;
  assign ld_err    = ld_err_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_read  = mem_read_q;
  assign mem_write = mem_write_q;
  assign freeze    = (state_q == S_LOAD);

endmodule
